// File: rtl/inst_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder_loader
// Description : Packs decoded RV32I field sets back into 32-bit instruction
//               words and writes them one after another into instruction
//               memory through a registered write port that honours
//               back-pressure. The program-load path uses it to build a
//               program in IMEM before the core is released.
// Ports       : clk, rst_n                  - clock, async active-low reset
//               start, base_addr, num_inst  - session control (used in IDLE)
//               in_valid/in_ready + fields  - decoded field-set stream
//               imem_we/imem_ready          - write request / IMEM accept
//               imem_addr, imem_wdata       - registered write address/data
//               busy, done, err             - status (err sticky per session)
// Revision    : 1.0 - initial release
// ============================================================================
module inst_encoder_loader #(
    parameter int INST_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [CNT_WIDTH-1:0]  num_inst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [4:0]            rd,
    input  logic [DATA_WIDTH-1:0] imm,
    output logic                  imem_we,
    input  logic                  imem_ready,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [INST_WIDTH-1:0] imem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    // RV32I opcodes
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_cal_i  = 7'b0010011;
    localparam logic [6:0] c_op_cal_r  = 7'b0110011;

    localparam logic [INST_WIDTH-1:0] c_nop = INST_WIDTH'(32'h0000_0013);

    localparam logic signed [DATA_WIDTH-1:0] c_i_min = DATA_WIDTH'(-2048);
    localparam logic signed [DATA_WIDTH-1:0] c_i_max = DATA_WIDTH'(2047);
    localparam logic signed [DATA_WIDTH-1:0] c_b_min = DATA_WIDTH'(-4096);
    localparam logic signed [DATA_WIDTH-1:0] c_b_max = DATA_WIDTH'(4094);
    localparam logic signed [DATA_WIDTH-1:0] c_j_min = DATA_WIDTH'(-1048576);
    localparam logic signed [DATA_WIDTH-1:0] c_j_max = DATA_WIDTH'(1048574);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CNT_WIDTH-1:0]    r_acc_left;   // field sets still to accept
    logic [CNT_WIDTH-1:0]    r_wr_left;    // words still to be taken by IMEM
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_we;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [INST_WIDTH-1:0]   r_wdata;
    logic                    r_err;

    logic                    w_accept;
    logic                    w_drain;
    logic                    w_start_ok;
    logic [INST_WIDTH-1:0]   w_word;
    logic                    w_enc_err;
    logic signed [DATA_WIDTH-1:0] w_simm;

    assign w_simm     = $signed(imm);
    // The output slot is free when empty or being drained this cycle, which
    // gives one word per cycle under continuous flow.
    assign in_ready   = (r_state == S_LOAD) && (r_acc_left != '0) && (!r_we || imem_ready);
    assign w_accept   = in_valid && in_ready;
    assign w_drain    = r_we && imem_ready;
    assign w_start_ok = (r_state == S_IDLE) && start;

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign busy       = (r_state == S_LOAD);
    assign done       = (r_state == S_DONE);
    assign err        = r_err;

    // Field re-packing; any encode error substitutes a NOP.
    always_comb begin
        w_word    = '0;
        w_enc_err = 1'b0;
        case (opcode)
            c_op_cal_r: begin
                w_word = {funct7, rs2, rs1, funct3, rd, opcode};
            end
            c_op_cal_i, c_op_load, c_op_jalr: begin
                if ((opcode == c_op_cal_i) && ((funct3 == 3'b001) || (funct3 == 3'b101)))
                    w_word = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                else
                    w_word = {imm[11:0], rs1, funct3, rd, opcode};
                w_enc_err = (w_simm < c_i_min) || (w_simm > c_i_max);
            end
            c_op_store: begin
                w_word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                w_enc_err = (w_simm < c_i_min) || (w_simm > c_i_max);
            end
            c_op_branch: begin
                w_word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                w_enc_err = imm[0] || (w_simm < c_b_min) || (w_simm > c_b_max);
            end
            c_op_lui, c_op_auipc: begin
                w_word    = {imm[31:12], rd, opcode};
                w_enc_err = (imm[11:0] != 12'd0);
            end
            c_op_jal: begin
                w_word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                w_enc_err = imm[0] || (w_simm < c_j_min) || (w_simm > c_j_max);
            end
            default: begin
                w_enc_err = 1'b1;
            end
        endcase
        if (w_enc_err)
            w_word = c_nop;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start)
                    w_state_nxt = (num_inst == '0) ? S_DONE : S_LOAD;
            end
            S_LOAD: begin
                // Leave once IMEM has taken the final word.
                if (w_drain && (r_wr_left == CNT_WIDTH'(1)))
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_left <= '0;
            r_wr_left  <= '0;
            r_ptr      <= '0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_ptr      <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
                r_acc_left <= num_inst;
                r_wr_left  <= num_inst;
                r_err      <= 1'b0;
            end
            if (w_accept) begin
                r_acc_left <= r_acc_left - CNT_WIDTH'(1);
                r_ptr      <= r_ptr + ADDR_WIDTH'(4);
                r_we       <= 1'b1;
                r_addr     <= r_ptr;
                r_wdata    <= w_word;
                r_err      <= r_err | w_enc_err;
            end else if (w_drain) begin
                r_we       <= 1'b0;
            end
            if (w_drain)
                r_wr_left  <= r_wr_left - CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_inst_encoder_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder_loader
// Description : Directed self-checking bench for inst_encoder_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] base_addr;
    logic [9:0]  num_inst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        imem_we;
    logic        imem_ready;
    logic [11:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [11:0] cap_addr[$];
    logic [31:0] cap_data[$];
    int          done_cnt = 0;

    inst_encoder_loader #(
        .INST_WIDTH(32), .DATA_WIDTH(32), .ADDR_WIDTH(12), .CNT_WIDTH(10)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .num_inst(num_inst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7(funct7), .rs1(rs1),
        .rs2(rs2), .rd(rd), .imm(imm), .imem_we(imem_we),
        .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every completed IMEM write and every done pulse.
    always @(posedge clk) begin
        if (rst_n && imem_we && imem_ready) begin
            cap_addr.push_back(imem_addr);
            cap_data.push_back(imem_wdata);
        end
        if (rst_n && done)
            done_cnt++;
    end

    task automatic begin_session(input logic [11:0] base, input logic [9:0] n);
        @(negedge clk);
        cap_addr.delete();
        cap_data.delete();
        base_addr = base;
        num_inst  = n;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdd,
                        input logic [31:0] im);
        bit ok;
        opcode = op; funct3 = f3; funct7 = f7; rs1 = r1; rs2 = r2; rd = rdd; imm = im;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            #1;
            if (in_ready) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout got=in_ready_low exp=accept op=%h", op);
        end
    endtask

    task automatic wait_done(input int prev);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (done_cnt != prev) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout got=%0d exp=%0d", done_cnt, prev + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, imem_we, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=00000", {in_ready, imem_we, busy, done, err});
        end
        checks++;
        if ({imem_addr, imem_wdata} !== 44'd0) begin
            errors++;
            $display("FAIL reset_bus got=%h/%h exp=0/0", imem_addr, imem_wdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [11:0] ea[3] = '{12'h100, 12'h104, 12'h108};
        logic [31:0] ed[3] = '{32'h00500093, 32'h002081B3, 32'h0020A423};
        int pd;
        pd = done_cnt;
        begin_session(12'h100, 10'd3);
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        send(7'h33, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        send(7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8);
        wait_done(pd);
        repeat (3) @(negedge clk);
        checks++;
        if (cap_addr.size() != 3) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=3", cap_addr.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (cap_addr[i] !== ea[i] || cap_data[i] !== ed[i]) begin
                    errors++;
                    $display("FAIL basic_word%0d got=%h@%h exp=%h@%h", i, cap_data[i], cap_addr[i], ed[i], ea[i]);
                end
            end
        end
        checks++;
        if (done_cnt != pd + 1) begin
            errors++;
            $display("FAIL basic_done_pulses got=%0d exp=1", done_cnt - pd);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err got=%b exp=0", err);
        end
    endtask

    task automatic test_formats;
        logic [31:0] ed[4] = '{32'hFE208EE3, 32'h008000EF, 32'h123452B7, 32'h40315093};
        int pd;
        pd = done_cnt;
        begin_session(12'h200, 10'd4);
        send(7'h63, 3'd0, 7'd0,  5'd1, 5'd2, 5'd0, 32'hFFFFFFFC);
        send(7'h6F, 3'd0, 7'd0,  5'd0, 5'd0, 5'd1, 32'd8);
        send(7'h37, 3'd0, 7'd0,  5'd0, 5'd0, 5'd5, 32'h12345000);
        send(7'h13, 3'd5, 7'h20, 5'd2, 5'd0, 5'd1, 32'd3);
        wait_done(pd);
        checks++;
        if (cap_data.size() != 4) begin
            errors++;
            $display("FAIL fmt_count got=%0d exp=4", cap_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (cap_data[i] !== ed[i] || cap_addr[i] !== 12'(12'h200 + 4 * i)) begin
                    errors++;
                    $display("FAIL fmt_word%0d got=%h@%h exp=%h@%h", i, cap_data[i], cap_addr[i], ed[i], 12'(12'h200 + 4 * i));
                end
            end
        end
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL fmt_err got=%b exp=0", err);
        end
    endtask

    task automatic test_stall;
        logic [11:0] ha;
        logic [31:0] hd;
        int pd;
        pd = done_cnt;
        begin_session(12'h300, 10'd3);
        imem_ready = 1'b0;
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1);
        ha = imem_addr;
        hd = imem_wdata;
        opcode = 7'h13; funct3 = 3'd0; rs1 = 5'd0; rd = 5'd2; imm = 32'd2;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0 || imem_we !== 1'b1 || imem_addr !== ha || imem_wdata !== hd) begin
                errors++;
                $display("FAIL stall_hold%0d got=rdy%b we%b %h@%h exp=rdy0 we1 %h@%h", i, in_ready, imem_we, imem_wdata, imem_addr, hd, ha);
            end
            @(negedge clk);
        end
        imem_ready = 1'b1;
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'd2);
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd3);
        wait_done(pd);
        checks++;
        if (cap_data.size() != 3 || cap_addr[0] !== 12'h300 || cap_addr[1] !== 12'h304 || cap_addr[2] !== 12'h308
            || cap_data[0] !== 32'h00100093 || cap_data[1] !== 32'h00200113 || cap_data[2] !== 32'h00300193) begin
            errors++;
            $display("FAIL stall_stream got=n%0d exp=3 words 00100093@300 00200113@304 00300193@308", cap_data.size());
        end
    endtask

    task automatic test_errors;
        int pd;
        pd = done_cnt;
        begin_session(12'h400, 10'd2);
        send(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0);
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_set got=%b exp=1", err);
        end
        send(7'h63, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd3);
        wait_done(pd);
        checks++;
        if (cap_data.size() != 2 || cap_data[0] !== 32'h13 || cap_data[1] !== 32'h13) begin
            errors++;
            $display("FAIL err_nop got=n%0d exp=2 words 00000013", cap_data.size());
        end
        checks++;
        if (err !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got=%b exp=1", err);
        end
        pd = done_cnt;
        begin_session(12'h500, 10'd1);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clear got=%b exp=0", err);
        end
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5);
        wait_done(pd);
    endtask

    task automatic test_wrap;
        int pd;
        pd = done_cnt;
        begin_session(12'hFFC, 10'd2);
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1);
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd2, 32'd2);
        wait_done(pd);
        checks++;
        if (cap_addr.size() != 2 || cap_addr[0] !== 12'hFFC || cap_addr[1] !== 12'h000) begin
            errors++;
            $display("FAIL wrap_addr got=n%0d exp=FFC then 000", cap_addr.size());
        end
    endtask

    task automatic test_zero;
        int pd;
        pd = done_cnt;
        begin_session(12'h600, 10'd0);
        wait_done(pd);
        repeat (2) @(negedge clk);
        checks++;
        if (cap_addr.size() != 0 || done_cnt != pd + 1) begin
            errors++;
            $display("FAIL zero_session got=writes%0d dones%0d exp=writes0 dones1", cap_addr.size(), done_cnt - pd);
        end
    endtask

    task automatic test_reset_mid;
        begin_session(12'h700, 10'd3);
        imem_ready = 1'b0;
        send(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd1);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, imem_we, busy, done, err} !== 5'b0 || imem_addr !== 12'd0 || imem_wdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid got=%b %h@%h exp=00000 0@0", {in_ready, imem_we, busy, done, err}, imem_wdata, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || imem_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_idle got=busy%b we%b exp=busy0 we0", busy, imem_we);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_inst = '0;
        in_valid = 1'b0; opcode = '0; funct3 = '0; funct7 = '0;
        rs1 = '0; rs2 = '0; rd = '0; imm = '0; imem_ready = 1'b1;
        test_reset;
        test_basic;
        test_formats;
        test_stall;
        test_errors;
        test_wrap;
        test_zero;
        test_reset_mid;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
